// File: rtl/tw_modmul_2lane_if.sv
// tw_modmul_2lane_if: operand/result bus for the two-lane Goldilocks twiddle multiplier.
interface tw_modmul_2lane_if #(parameter int W = 128);
  logic         in_valid;
  logic [W-1:0] data_in;
  logic [W-1:0] tw_in;
  logic         out_valid;
  logic [W-1:0] data_out;
  modport master (output in_valid, data_in, tw_in, input out_valid, data_out);
  modport slave  (input in_valid, data_in, tw_in, output out_valid, data_out);
endinterface

// File: rtl/tw_modmul_2lane.sv
// tw_modmul_2lane: two-lane 4-stage (a*w) mod 0xFFFFFFFF00000001 pipeline, frozen while CEN is high.
// Optional TWMUL_RANGE_CHK_EN adds a sticky range_err flag for non-canonical operands.
module tw_modmul_2lane #(
  parameter int          P_WIDTH = 128,
  parameter int          LANE_W  = 64,
  parameter logic [63:0] MOD     = 64'hFFFFFFFF00000001
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic CEN,
`ifdef TWMUL_RANGE_CHK_EN
  output logic range_err,
`endif
  tw_modmul_2lane_if.slave bus
);
  localparam int H = LANE_W / 2;
  logic [3:0]         v_q, v_d;
  logic [P_WIDTH-1:0] y_all;
  assign v_d = {v_q[2:0], bus.in_valid};
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) v_q <= '0;
    else if (!CEN) v_q <= v_d;
  assign bus.out_valid = v_q[3];
  assign bus.data_out  = y_all;
  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [H-1:0]         a_lo, a_hi, w_lo, w_hi, xhl, xhh;
    logic [3:0][63:0]     pp_q, pp_d;
    logic [127:0]         x_q, x_d;
    logic [63:0]          xlo, t0, t1, r_q, r_d, y_q, y_d;
    logic [64:0]          s;
    assign a_lo = bus.data_in[g*LANE_W +: H];
    assign a_hi = bus.data_in[g*LANE_W+H +: H];
    assign w_lo = bus.tw_in[g*LANE_W +: H];
    assign w_hi = bus.tw_in[g*LANE_W+H +: H];
    assign pp_d = {64'(a_hi) * 64'(w_hi), 64'(a_hi) * 64'(w_lo),
                   64'(a_lo) * 64'(w_hi), 64'(a_lo) * 64'(w_lo)};
    assign x_d = {64'd0, pp_q[0]} + ({64'd0, pp_q[1]} << 32) + ({64'd0, pp_q[2]} << 32) + {pp_q[3], 64'd0};
    assign {xhh, xhl, xlo} = x_q;
    // 2^96 = -1 and 2^64 = 2^32-1 (mod p): a wrap of 2^64 is undone by subtracting 2^32-1
    assign t0  = xlo < {32'd0, xhh} ? xlo - {32'd0, xhh} - 64'hFFFFFFFF : xlo - {32'd0, xhh};
    assign t1  = {32'd0, xhl} * 64'hFFFFFFFF;
    assign s   = {1'b0, t0} + {1'b0, t1};
    assign r_d = s[64] ? s[63:0] + 64'hFFFFFFFF : s[63:0];
    assign y_d = r_q >= MOD ? r_q - MOD : r_q;
    always_ff @(posedge CLK or negedge rst_n)
      if (!rst_n) begin
        pp_q <= '0;
        x_q  <= '0;
        r_q  <= '0;
        y_q  <= '0;
      end else if (!CEN) begin
        pp_q <= pp_d;
        x_q  <= x_d;
        r_q  <= r_d;
        y_q  <= y_d;
      end
    assign y_all[g*LANE_W +: LANE_W] = y_q;
  end
`ifdef TWMUL_RANGE_CHK_EN
  logic range_err_q, range_err_d;
  assign range_err_d = range_err_q | (bus.in_valid &&
    (bus.data_in[127:64] >= MOD || bus.data_in[63:0] >= MOD ||
     bus.tw_in[127:64] >= MOD || bus.tw_in[63:0] >= MOD));
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) range_err_q <= 1'b0;
    else if (!CEN) range_err_q <= range_err_d;
  assign range_err = range_err_q;
`endif
endmodule

// File: tb/tb_tw_modmul_2lane.sv
// tb_tw_modmul_2lane: random and directed stimulus against a modular-arithmetic reference model.
module tb_tw_modmul_2lane;
  localparam logic [63:0] P = 64'hFFFFFFFF00000001;
  logic clk = 0, rst_n = 0, CEN = 0, mon_en = 0;
  int checks = 0, errors = 0;
  logic [127:0] q[$];
  logic [127:0] last_d;
  logic last_v;
`ifdef TWMUL_RANGE_CHK_EN
  logic range_err;
`endif
  tw_modmul_2lane_if bus ();
  tw_modmul_2lane dut (
    .CLK(clk), .rst_n(rst_n), .CEN(CEN),
`ifdef TWMUL_RANGE_CHK_EN
    .range_err(range_err),
`endif
    .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] w);
    logic [127:0] x;
    x = {64'd0, a} * {64'd0, w};
    return 64'(x % {64'd0, P});
  endfunction
  function automatic logic [63:0] rval(input bit canon);
    logic [63:0] v;
    int k;
    k = canon ? $urandom_range(0, 6) : $urandom_range(0, 9);
    v = {$urandom, $urandom};
    case (k)
      0: v = 0;
      1: v = 1;
      2: v = P - 1;
      3: v = 64'h1_0000_0000;
      4: v = 64'd1 << 48;
      7: v = P;
      8: v = '1;
      9: v = P + 5;
      default: v = (canon && v >= P) ? v - P : v;
    endcase
    return v;
  endfunction
  task automatic drive(input logic v, input logic c, input logic [63:0] a1, w1, a0, w0);
    @(negedge clk);
    bus.in_valid = v;
    CEN = c;
    bus.data_in = {a1, a0};
    bus.tw_in = {w1, w0};
    if (v && !c) q.push_back({mulmod(a1, w1), mulmod(a0, w0)});
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask
  task automatic run_known(input string tag, input logic [63:0] a1, w1, a0, w0, input logic [127:0] exp);
    drive(1, 0, a1, w1, a0, w0);
    for (int k = 0; k < 3; k++) begin
      idle();
      check({tag, "_lat"}, bus.out_valid, 0);
    end
    idle();
    check({tag, "_v"}, bus.out_valid, 1);
    check(tag, bus.data_out, exp);
  endtask
  task automatic random_run(input int n, input bit canon, input bit stalls);
    for (int i = 0; i < n; i++)
      drive($urandom_range(0, 3) != 0, stalls && $urandom_range(0, 4) == 0,
            rval(canon), rval(canon), rval(canon), rval(canon));
    repeat (6) idle();
    check("drained", 128'(q.size()), 0);
  endtask
  // Scoreboard: results must emerge in order; during a stall the outputs must hold.
  always @(posedge clk) begin
    logic cen_e;
    logic [127:0] exp;
    cen_e = CEN;
    #1;
    if (rst_n && mon_en) begin
      if (cen_e) begin
        check("hold_v", bus.out_valid, last_v);
        check("hold_d", bus.data_out, last_d);
      end else if (bus.out_valid) begin
        if (q.size() == 0) check("extra_out", bus.out_valid, 0);
        else begin
          exp = q.pop_front();
          check("stream", bus.data_out, exp);
        end
      end
    end
    last_v = bus.out_valid;
    last_d = bus.data_out;
  end
  initial begin
    bus.in_valid = 0;
    bus.data_in = 0;
    bus.tw_in = 0;
    repeat (2) @(negedge clk);
    check("rst_v", bus.out_valid, 0);
    check("rst_d", bus.data_out, 0);
`ifdef TWMUL_RANGE_CHK_EN
    check("rst_rerr", range_err, 0);
`endif
    rst_n = 1;
    mon_en = 1;
    run_known("small", 5, 7, 2, 3, {64'h23, 64'h6});
    run_known("pm1_2p32", 64'h1_0000_0000, 64'h1_0000_0000, P - 1, P - 1, {64'h00000000FFFFFFFF, 64'h1});
`ifdef TWMUL_RANGE_CHK_EN
    check("rerr_canon", range_err, 0);
`endif
    run_known("2p48_max", '1, 1, 64'd1 << 48, 64'd1 << 48, {64'h00000000FFFFFFFE, 64'hFFFFFFFF00000000});
`ifdef TWMUL_RANGE_CHK_EN
    check("rerr_noncanon", range_err, 1);
`endif
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, rval(0), rval(0), rval(0), rval(0));
      if (i == 2) repeat (2) drive(1, 1, rval(0), rval(0), rval(0), rval(0));
    end
    repeat (6) idle();
    check("stall_drained", 128'(q.size()), 0);
    random_run(150, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, rval(0), rval(0), rval(0), rval(0));
    mon_en = 0;
    @(negedge clk);
    rst_n = 0;
    bus.in_valid = 0;
    #1;
    check("midrst_v", bus.out_valid, 0);
    check("midrst_d", bus.data_out, 0);
`ifdef TWMUL_RANGE_CHK_EN
    check("midrst_rerr", range_err, 0);
`endif
    q.delete();
    @(negedge clk);
    rst_n = 1;
    mon_en = 1;
    for (int i = 0; i < 6; i++) begin
      idle();
      check("post_rst_v", bus.out_valid, 0);
    end
    random_run(100, 1, 1);
`ifdef TWMUL_RANGE_CHK_EN
    check("rerr_canon_stream", range_err, 0);
    drive(1, 0, P, rval(1), rval(1), rval(1));
    idle();
    check("rerr_set", range_err, 1);
    repeat (4) idle();
    check("rerr_sticky", range_err, 1);
    check("rerr_lane1", bus.data_out[127:64], 0);
    check("rerr_drained", 128'(q.size()), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
